// File: rtl/fifo_pkg.sv
// fifo_pkg: shared sizing helpers for the parametrised FIFO
package fifo_pkg;
  typedef int unsigned width_t;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction
  function automatic width_t ptr_width(input int depth);
    return width_t'(clog2(depth) + 1);
  endfunction
endpackage

// File: rtl/fifo_ram.sv
// fifo_ram: WIDTH x DEPTH dual-port array, sync write (i_we/i_waddr/i_wdata), async read (i_raddr -> o_rdata)
module fifo_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 32,
  parameter int AW = 5
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  always_ff @(posedge clk) if (i_we) r_mem[i_waddr] <= i_wdata;
  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/sync_fifo_n.sv
// sync_fifo_n: single-clock FIFO; write (wr_en/wr_data), read (rd_en -> rd_data/rd_valid), status (full/empty/almost_*/level), sticky errors (overflow/underflow, cleared by clr_err)
module sync_fifo_n
  import fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 32,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int FWFT = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic [WIDTH-1:0]            wr_data,
  input  logic                        rd_en,
  output logic [WIDTH-1:0]            rd_data,
  output logic                        rd_valid,
  output logic                        full,
  output logic                        empty,
  output logic                        almost_full,
  output logic                        almost_empty,
  output logic [ptr_width(DEPTH)-1:0] level,
  output logic                        overflow,
  output logic                        underflow,
  input  logic                        clr_err
);
  localparam int AW = clog2(DEPTH);
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $fatal(1, "sync_fifo_n: DEPTH must be a power of two >= 2");
  end
  if (AF_LEVEL < 0 || AF_LEVEL > DEPTH || AE_LEVEL < 0 || AE_LEVEL > DEPTH) begin : g_bad_level
    $fatal(1, "sync_fifo_n: thresholds must lie in 0..DEPTH");
  end
  localparam logic [AW:0] AF_L = AF_LEVEL[AW:0];
  localparam logic [AW:0] AE_L = AE_LEVEL[AW:0];
  logic [AW:0]      r_wr_ptr, r_rd_ptr;
  logic             r_ovf, r_unf;
  logic             w_rd_fire, w_wr_fire;
  logic [WIDTH-1:0] w_ram_q;
  assign empty        = r_wr_ptr == r_rd_ptr;
  assign full         = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign level        = r_wr_ptr - r_rd_ptr;
  assign almost_full  = level >= AF_L;
  assign almost_empty = level <= AE_L;
  assign overflow     = r_ovf;
  assign underflow    = r_unf;
  assign w_rd_fire    = rd_en & ~empty;
  // a pop in the same cycle frees the slot, so a full FIFO still accepts the write
  assign w_wr_fire    = wr_en & (~full | w_rd_fire);
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else begin
      r_wr_ptr <= r_wr_ptr + {{AW{1'b0}}, w_wr_fire};
      r_rd_ptr <= r_rd_ptr + {{AW{1'b0}}, w_rd_fire};
      r_ovf    <= (wr_en & ~w_wr_fire) | (r_ovf & ~clr_err);
      r_unf    <= (rd_en & empty) | (r_unf & ~clr_err);
    end
  end
  fifo_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk     (clk),
    .i_we    (w_wr_fire),
    .i_waddr (r_wr_ptr[AW-1:0]),
    .i_wdata (wr_data),
    .i_raddr (r_rd_ptr[AW-1:0]),
    .o_rdata (w_ram_q)
  );
  if (FWFT != 0) begin : g_fwft
    assign rd_data  = w_ram_q;
    assign rd_valid = ~empty;
  end else begin : g_reg
    logic [WIDTH-1:0] r_rd_data;
    logic             r_rd_valid;
    always_ff @(posedge clk) begin
      if (rst) begin
        r_rd_data  <= '0;
        r_rd_valid <= 1'b0;
      end else begin
        r_rd_valid <= w_rd_fire;
        r_rd_data  <= w_rd_fire ? w_ram_q : r_rd_data;
      end
    end
    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
  end
endmodule

// File: tb/tb_sync_fifo_n.sv
// tb_sync_fifo_n: randomized scoreboard bench for registered-read and FWFT FIFO variants
module tb_sync_fifo_n;
  logic       clk = 1'b0, rst;
  logic       wr_en, rd_en, clr_err;
  logic [7:0] wr_data, rd_data;
  logic       rd_valid, full, empty, af, ae, ovf, unf;
  logic [3:0] level;
  logic       f_wr_en, f_rd_en, f_clr_err;
  logic [7:0] f_wr_data, f_rd_data;
  logic       f_rd_valid, f_full, f_empty, f_af, f_ae, f_ovf, f_unf;
  logic [2:0] f_level;
  int         vecs = 0, errs = 0;
  logic [7:0] mq[$], exp_q[$];
  bit         m_ovf, m_unf;
  logic [7:0] mon_e;
  always #5 clk = ~clk;
  sync_fifo_n #(.WIDTH(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(1), .FWFT(0)) u_dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .full(full), .empty(empty),
    .almost_full(af), .almost_empty(ae), .level(level), .overflow(ovf),
    .underflow(unf), .clr_err(clr_err)
  );
  sync_fifo_n #(.WIDTH(8), .DEPTH(4), .FWFT(1)) u_fw (
    .clk(clk), .rst(rst), .wr_en(f_wr_en), .wr_data(f_wr_data), .rd_en(f_rd_en),
    .rd_data(f_rd_data), .rd_valid(f_rd_valid), .full(f_full), .empty(f_empty),
    .almost_full(f_af), .almost_empty(f_ae), .level(f_level), .overflow(f_ovf),
    .underflow(f_unf), .clr_err(f_clr_err)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic check_status();
    int n;
    n = mq.size();
    chk("level", 32'(level), n);
    chk("full", 32'(full), 32'(n == 8));
    chk("empty", 32'(empty), 32'(n == 0));
    chk("almost_full", 32'(af), 32'(n >= 6));
    chk("almost_empty", 32'(ae), 32'(n <= 1));
    chk("overflow", 32'(ovf), 32'(m_ovf));
    chk("underflow", 32'(unf), 32'(m_unf));
  endtask
  task automatic step(input bit w, input bit r, input logic [7:0] d, input bit c);
    bit was_empty, rf, wf;
    logic [7:0] head;
    was_empty = mq.size() == 0;
    rf = r && !was_empty;
    wf = w && (mq.size() < 8 || rf);
    wr_en = w; rd_en = r; wr_data = d; clr_err = c;
    head = 8'h00;
    if (rf) head = mq.pop_front();
    if (wf) mq.push_back(d);
    m_ovf = (w && !wf) || (m_ovf && !c);
    m_unf = (r && was_empty) || (m_unf && !c);
    @(posedge clk);
    if (rf) exp_q.push_back(head);
    #1;
    wr_en = 0; rd_en = 0; clr_err = 0;
    check_status();
  endtask
  task automatic do_reset(input bit busy);
    rst = 1; wr_en = busy; rd_en = busy; wr_data = 8'hEE; clr_err = 0;
    @(posedge clk);
    mq.delete(); exp_q.delete(); m_ovf = 0; m_unf = 0;
    #1;
    rst = 0; wr_en = 0; rd_en = 0;
    check_status();
    chk("rst_rd_valid", 32'(rd_valid), 0);
    chk("rst_rd_data", 32'(rd_data), 0);
  endtask
  task automatic f_cycle(input bit w, input bit r, input logic [7:0] d, input bit c);
    f_wr_en = w; f_rd_en = r; f_wr_data = d; f_clr_err = c;
    @(posedge clk); #1;
    f_wr_en = 0; f_rd_en = 0; f_clr_err = 0;
  endtask
  always @(negedge clk) begin
    if (rd_valid) begin
      if (exp_q.size() == 0) begin
        vecs++; errs++;
        $display("FAIL rd_valid_unexpected: got rd_valid=1 data=%0h expected no read", rd_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rd_data", 32'(rd_data), 32'(mon_e));
      end
    end else if (exp_q.size() != 0) begin
      vecs++; errs++;
      $display("FAIL rd_valid_missing: got rd_valid=0 expected data %0h", exp_q[0]);
      exp_q.delete();
    end
  end
  initial begin
    rst = 1; wr_en = 0; rd_en = 0; clr_err = 0; wr_data = 0;
    f_wr_en = 0; f_rd_en = 0; f_clr_err = 0; f_wr_data = 0;
    do_reset(0);
    chk("f_rst_empty", 32'(f_empty), 1);
    chk("f_rst_valid", 32'(f_rd_valid), 0);
    chk("f_rst_level", 32'(f_level), 0);
    repeat (3) step(0, 0, 8'h00, 0);
    f_cycle(1, 0, 8'h5A, 0);
    chk("f_head", 32'(f_rd_data), 32'h5A);
    chk("f_valid", 32'(f_rd_valid), 1);
    f_cycle(0, 1, 8'h00, 0);
    chk("f_empty_after_pop", 32'(f_empty), 1);
    chk("f_valid_after_pop", 32'(f_rd_valid), 0);
    chk("f_unf_clean", 32'(f_unf), 0);
    f_cycle(0, 1, 8'h00, 0);
    chk("f_underflow", 32'(f_unf), 1);
    f_cycle(0, 0, 8'h00, 1);
    chk("f_clr_err", 32'(f_unf), 0);
    for (int i = 0; i < 5; i++) f_cycle(1, 0, 8'hA0 + 8'(i), 0);
    chk("f_full", 32'(f_full), 1);
    chk("f_overflow", 32'(f_ovf), 1);
    for (int i = 0; i < 4; i++) begin
      chk("f_order", 32'(f_rd_data), 32'hA0 + i);
      f_cycle(0, 1, 8'h00, 0);
    end
    chk("f_drained", 32'(f_empty), 1);
    for (int i = 1; i <= 9; i++) step(1, 0, 8'(8'h11 * i), 0);
    step(0, 0, 8'h00, 1);
    step(1, 1, 8'hAA, 0);
    repeat (9) step(0, 1, 8'h00, 0);
    step(1, 1, 8'h3C, 0);
    step(0, 1, 8'h00, 1);
    do_reset(0);
    for (int i = 0; i < 20; i++) begin
      step(1, 0, 8'(i + 1), 0);
      step(0, 1, 8'h00, 0);
    end
    do_reset(0);
    for (int i = 0; i < 6; i++) step(1, 0, 8'(8'hC0 + i), 0);
    step(0, 1, 8'h00, 0);
    do_reset(1);
    for (int i = 0; i < 600; i++) begin
      int bias;
      bias = (i / 100) % 2 == 0 ? 70 : 30;
      step($urandom_range(0, 99) < bias, $urandom_range(0, 99) >= bias - 20,
           8'($urandom), $urandom_range(0, 19) == 0);
      if ($urandom_range(0, 249) == 0) do_reset($urandom_range(0, 1) == 1);
    end
    repeat (10) step(0, 1, 8'h00, 0);
    @(negedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
